// File: rtl/bp_fetch_unit.sv
// bp_fetch_unit
// Fetch-stage PC register with a direct-mapped, tagged branch target buffer.
// Each BTB entry holds its own CNT_W-bit saturating direction counter.
//
// Ports:
//   clk, rst        : rising-edge clock, asynchronous active-high reset
//   pc_write        : 1 lets the PC advance, 0 holds it (load-use stall)
//   pc              : registered fetch PC
//   btb_hit         : pc found a valid entry with a matching tag
//   pred_taken      : btb_hit and counter MSB set
//   pred_target     : stored target of the hit entry, 0 on a miss
//   upd_valid       : a resolved conditional branch arrives from MEM
//   upd_pc          : PC of that branch
//   upd_taken       : its actual direction
//   upd_target      : its actual taken target
//   upd_mispredict  : the prediction was wrong, redirect fetch
//   mispred_cnt     : saturating count of accepted mispredicts
module bp_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              ENTRIES  = 16,
    parameter int              CNT_W    = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_write,
    output logic [XLEN-1:0] pc,
    output logic            btb_hit,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_mispredict,
    output logic [31:0]     mispred_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    // Weakly-taken is the allocation value, weakly-not-taken the reset value.
    // With CNT_W=1 these collapse to 1 and 0.
    localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1) << (CNT_W - 1);
    localparam logic [CNT_W-1:0] CNT_WNT = CNT_WT - CNT_W'(1);

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] cnt_dec(input logic [CNT_W-1:0] c);
        return (|c) ? c - CNT_W'(1) : c;
    endfunction

    logic             btb_valid  [ENTRIES];
    logic [TAG_W-1:0] btb_tag    [ENTRIES];
    logic [XLEN-1:0]  btb_target [ENTRIES];
    logic [CNT_W-1:0] btb_cnt    [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic             redirect;
    logic [XLEN-1:0]  pc_next;

    // Instructions are word aligned, so the low two PC bits carry no information.
    logic unused_bits;
    assign unused_bits = ^{pc[1:0], upd_pc[1:0]};

    assign lk_idx  = pc[IDX_W+1:2];
    assign lk_tag  = pc[XLEN-1:IDX_W+2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[XLEN-1:IDX_W+2];

    // Lookup stage: combinational from the registered pc, reads pre-edge contents.
    assign btb_hit     = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag);
    assign pred_taken  = btb_hit && btb_cnt[lk_idx][CNT_W-1];
    assign pred_target = btb_hit ? btb_target[lk_idx] : '0;

    assign upd_hit  = btb_valid[upd_idx] && (btb_tag[upd_idx] == upd_tag);
    assign redirect = upd_valid && upd_mispredict;

    // A redirect from MEM outranks a stall: the stalled instruction is squashed.
    always_comb begin
        pc_next = pc + XLEN'(4);
        if (redirect) begin
            pc_next = upd_taken ? upd_target : upd_pc + XLEN'(4);
        end else if (!pc_write) begin
            pc_next = pc;
        end else if (pred_taken) begin
            pc_next = pred_target;
        end
    end

    // PC / mispredict counter stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            mispred_cnt <= '0;
        end else begin
            pc <= pc_next;
            if (redirect && !(&mispred_cnt)) begin
                mispred_cnt <= mispred_cnt + 32'd1;
            end
        end
    end

    // BTB training stage: runs regardless of pc_write; not-taken misses never allocate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_valid[i]  <= 1'b0;
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
                btb_cnt[i]    <= CNT_WNT;
            end
        end else if (upd_valid) begin
            if (upd_hit) begin
                btb_cnt[upd_idx] <= upd_taken ? cnt_inc(btb_cnt[upd_idx])
                                              : cnt_dec(btb_cnt[upd_idx]);
                if (upd_taken) begin
                    btb_target[upd_idx] <= upd_target;
                end
            end else if (upd_taken) begin
                btb_valid[upd_idx]  <= 1'b1;
                btb_tag[upd_idx]    <= upd_tag;
                btb_target[upd_idx] <= upd_target;
                btb_cnt[upd_idx]    <= CNT_WT;
            end
        end
    end

endmodule

// File: tb/tb_bp_fetch_unit.sv
module tb_bp_fetch_unit;

    localparam int          XLEN     = 32;
    localparam int          ENTRIES  = 16;
    localparam int          CNT_W    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          CMAX     = (1 << CNT_W) - 1;
    localparam int          CHALF    = 1 << (CNT_W - 1);

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_write;
    logic [31:0] pc;
    logic        btb_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispredict;
    logic [31:0] mispred_cnt;

    int checks = 0;
    int errors = 0;

    bp_fetch_unit #(
        .XLEN(XLEN), .ENTRIES(ENTRIES), .CNT_W(CNT_W), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk), .rst(rst), .pc_write(pc_write), .pc(pc),
        .btb_hit(btb_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: table of entries keyed by word index modulo ENTRIES,
    // counter kept as a plain integer clamped to [0, CMAX].
    bit          m_valid  [ENTRIES];
    logic [31:0] m_tag    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          m_cnt    [ENTRIES];
    logic [31:0] m_pc;
    longint      m_mis;

    function automatic int idx_of(input logic [31:0] a);
        return int'((a / 4) % ENTRIES);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] a);
        return a / (4 * ENTRIES);
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        return m_valid[idx_of(a)] && (m_tag[idx_of(a)] == tag_of(a));
    endfunction

    function automatic bit m_taken(input logic [31:0] a);
        return m_hit(a) && (m_cnt[idx_of(a)] >= CHALF);
    endfunction

    function automatic logic [31:0] m_tgt(input logic [31:0] a);
        return m_hit(a) ? m_target[idx_of(a)] : 32'h0;
    endfunction

    task automatic model_reset();
        m_pc  = RESET_PC;
        m_mis = 0;
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i]  = 1'b0;
            m_tag[i]    = 32'h0;
            m_target[i] = 32'h0;
            m_cnt[i]    = CHALF - 1;
        end
    endtask

    task automatic model_edge();
        logic [31:0] npc;
        int i;
        if (upd_valid && upd_mispredict) npc = upd_taken ? upd_target : upd_pc + 32'd4;
        else if (!pc_write)              npc = m_pc;
        else if (m_taken(m_pc))          npc = m_tgt(m_pc);
        else                             npc = m_pc + 32'd4;
        if (upd_valid) begin
            i = idx_of(upd_pc);
            if (m_hit(upd_pc)) begin
                if (upd_taken) begin
                    m_cnt[i]    = (m_cnt[i] + 1 > CMAX) ? CMAX : m_cnt[i] + 1;
                    m_target[i] = upd_target;
                end else begin
                    m_cnt[i] = (m_cnt[i] - 1 < 0) ? 0 : m_cnt[i] - 1;
                end
            end else if (upd_taken) begin
                m_valid[i]  = 1'b1;
                m_tag[i]    = tag_of(upd_pc);
                m_target[i] = upd_target;
                m_cnt[i]    = CHALF;
            end
        end
        if (upd_valid && upd_mispredict && m_mis < 64'h0000_0000_FFFF_FFFF) m_mis++;
        m_pc = npc;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pc_write       = 1'b1;
        upd_valid      = 1'b0;
        upd_pc         = 32'h0;
        upd_taken      = 1'b0;
        upd_target     = 32'h0;
        upd_mispredict = 1'b0;
    endtask

    task automatic set_upd(input logic [31:0] a, input logic tk,
                           input logic [31:0] t, input logic mis);
        upd_valid      = 1'b1;
        upd_pc         = a;
        upd_taken      = tk;
        upd_target     = t;
        upd_mispredict = mis;
    endtask

    // Steer fetch to addr with a not-taken mispredict of the preceding word.
    task automatic redirect_to(input logic [31:0] addr);
        set_upd(addr - 32'd4, 1'b0, 32'h0, 1'b1);
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        checks++; if (pc !== RESET_PC) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, RESET_PC); end
        checks++; if (btb_hit !== 1'b0) begin errors++; $display("FAIL reset_hit got %b exp 0", btb_hit); end
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_taken got %b exp 0", pred_taken); end
        checks++; if (pred_target !== 32'h0) begin errors++; $display("FAIL reset_target got %h exp 0", pred_target); end
        checks++; if (mispred_cnt !== 32'h0) begin errors++; $display("FAIL reset_miscnt got %0d exp 0", mispred_cnt); end
    endtask

    task automatic test_sequential();
        for (int k = 0; k < 5; k++) begin
            checks++; if (pc !== 32'(4 * k)) begin errors++; $display("FAIL seq_pc step %0d got %h exp %h", k, pc, 32'(4 * k)); end
            checks++; if (btb_hit !== 1'b0) begin errors++; $display("FAIL seq_hit step %0d got %b exp 0", k, btb_hit); end
            if (k < 4) tick();
        end
    endtask

    task automatic test_train_predict();
        set_upd(32'h40, 1'b1, 32'h100, 1'b1);
        tick();
        idle();
        checks++; if (pc !== 32'h100) begin errors++; $display("FAIL train_redirect got %h exp 00000100", pc); end
        redirect_to(32'h40);
        checks++; if (pc !== 32'h40) begin errors++; $display("FAIL train_goto got %h exp 00000040", pc); end
        checks++; if (btb_hit !== 1'b1) begin errors++; $display("FAIL train_hit got %b exp 1", btb_hit); end
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL train_taken got %b exp 1", pred_taken); end
        checks++; if (pred_target !== 32'h100) begin errors++; $display("FAIL train_target got %h exp 00000100", pred_target); end
        tick();
        checks++; if (pc !== 32'h100) begin errors++; $display("FAIL train_follow got %h exp 00000100", pc); end
        checks++; if (mispred_cnt !== 32'd2) begin errors++; $display("FAIL train_miscnt got %0d exp 2", mispred_cnt); end
    endtask

    task automatic test_alias();
        redirect_to(32'h80);
        checks++; if (btb_hit !== 1'b0) begin errors++; $display("FAIL alias_hit got %b exp 0", btb_hit); end
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL alias_taken got %b exp 0", pred_taken); end
        checks++; if (pred_target !== 32'h0) begin errors++; $display("FAIL alias_target got %h exp 0", pred_target); end
        tick();
        checks++; if (pc !== 32'h84) begin errors++; $display("FAIL alias_next got %h exp 00000084", pc); end
    endtask

    task automatic test_saturation();
        repeat (3) begin
            set_upd(32'h40, 1'b1, 32'h100, 1'b0);
            tick();
        end
        set_upd(32'h40, 1'b0, 32'h0, 1'b0);
        tick();
        idle();
        redirect_to(32'h40);
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL sat_after_one_nt got %b exp 1", pred_taken); end
        // Second not-taken while holding at 0x40; the prediction this cycle is pre-edge.
        pc_write = 1'b0;
        set_upd(32'h40, 1'b0, 32'h0, 1'b0);
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL sat_no_bypass got %b exp 1", pred_taken); end
        tick();
        idle();
        checks++; if (pc !== 32'h40) begin errors++; $display("FAIL sat_hold got %h exp 00000040", pc); end
        checks++; if (btb_hit !== 1'b1) begin errors++; $display("FAIL sat_hit got %b exp 1", btb_hit); end
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL sat_after_two_nt got %b exp 0", pred_taken); end
        tick();
        checks++; if (pc !== 32'h44) begin errors++; $display("FAIL sat_next got %h exp 00000044", pc); end
    endtask

    task automatic test_stall_redirect();
        longint mis_before;
        mis_before = m_mis;
        pc_write = 1'b0;
        tick();
        checks++; if (pc !== 32'h44) begin errors++; $display("FAIL stall_hold got %h exp 00000044", pc); end
        set_upd(32'h20, 1'b0, 32'h0, 1'b1);
        tick();
        idle();
        pc_write = 1'b0;
        checks++; if (pc !== 32'h24) begin errors++; $display("FAIL stall_redirect got %h exp 00000024", pc); end
        checks++; if (mispred_cnt !== 32'(mis_before + 1)) begin errors++; $display("FAIL stall_miscnt got %0d exp %0d", mispred_cnt, mis_before + 1); end
        tick();
        idle();
        checks++; if (pc !== 32'h24) begin errors++; $display("FAIL stall_hold2 got %h exp 00000024", pc); end
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return 32'hFFFF_FFC0 | 32'($urandom_range(0, 15) << 2);
        return 32'($urandom_range(0, 3) << 6) | 32'($urandom_range(0, 15) << 2);
    endfunction

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            pc_write       = ($urandom_range(0, 4) != 0);
            upd_valid      = ($urandom_range(0, 9) < 4);
            upd_pc         = rand_addr();
            upd_taken      = $urandom_range(0, 1);
            upd_target     = rand_addr();
            upd_mispredict = ($urandom_range(0, 9) < 3);
            checks++; if (pc !== m_pc) begin errors++; $display("FAIL rnd_pc cycle %0d got %h exp %h", n, pc, m_pc); end
            checks++; if (btb_hit !== m_hit(m_pc)) begin errors++; $display("FAIL rnd_hit cycle %0d got %b exp %b", n, btb_hit, m_hit(m_pc)); end
            checks++; if (pred_taken !== m_taken(m_pc)) begin errors++; $display("FAIL rnd_taken cycle %0d got %b exp %b", n, pred_taken, m_taken(m_pc)); end
            checks++; if (pred_target !== m_tgt(m_pc)) begin errors++; $display("FAIL rnd_target cycle %0d got %h exp %h", n, pred_target, m_tgt(m_pc)); end
            checks++; if (mispred_cnt !== 32'(m_mis)) begin errors++; $display("FAIL rnd_miscnt cycle %0d got %0d exp %0d", n, mispred_cnt, m_mis); end
            tick();
        end
        idle();
    endtask

    task automatic test_async_reset();
        set_upd(32'h40, 1'b1, 32'h200, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (pc !== RESET_PC) begin errors++; $display("FAIL arst_immediate got %h exp %h", pc, RESET_PC); end
        checks++; if (mispred_cnt !== 32'h0) begin errors++; $display("FAIL arst_miscnt got %0d exp 0", mispred_cnt); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        model_reset();
        checks++; if (pc !== RESET_PC) begin errors++; $display("FAIL arst_held got %h exp %h", pc, RESET_PC); end
        redirect_to(32'h40);
        checks++; if (pc !== 32'h40) begin errors++; $display("FAIL arst_goto got %h exp 00000040", pc); end
        checks++; if (btb_hit !== 1'b0) begin errors++; $display("FAIL arst_cleared got %b exp 0", btb_hit); end
        checks++; if (mispred_cnt !== 32'd1) begin errors++; $display("FAIL arst_miscnt2 got %0d exp 1", mispred_cnt); end
        tick();
        checks++; if (pc !== 32'h44) begin errors++; $display("FAIL arst_next got %h exp 00000044", pc); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_train_predict();
        test_alias();
        test_saturation();
        test_stall_redirect();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
